// File: rtl/spi_slave_byte_if.sv
// SPI mode-3 responder: oversampled SCLK/CSn/MOSI, 8-bit MSB-first frames, 1-deep tx holding buffer.
// Latency: MISO updates / rx_valid_o pulses a few clk_i cycles after the sync chain sees the SCLK edge.
// Backpressure: tx side is valid/ready into the holding buffer; rx side has none (strobe only).
module spi_slave_byte_if #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEFAULT_TX  = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       spi_sclk_i,
    input  logic       spi_csn_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe_o,
    input  logic [7:0] tx_byte_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       tx_underrun_o,
    output logic       busy_o
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   csn_d;
    logic [2:0]             bit_cnt;
    logic [6:0]             rx_sr;
    logic [7:0]             tx_sr;
    logic [7:0]             hold;
    logic                   hold_full;

    logic sclk_s, csn_s, mosi_s;
    logic sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic byte_done, load_pt, accept;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;
    assign csn_rise  = ~csn_d & csn_s;
    assign csn_fall  = csn_d & ~csn_s;

    // The 8th rise of a byte both completes rx and reloads tx for the next byte.
    assign byte_done = (state == SHIFT) && sclk_rise && (bit_cnt == 3'd7);
    assign load_pt   = ((state == IDLE) && csn_fall) || byte_done;

    assign tx_ready_o = ~hold_full;
    assign accept     = tx_valid_i & tx_ready_o;

    // Input synchronisers, reset to the bus idle levels so reset never fakes an edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sclk_sync <= '1;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b1;
            csn_d     <= 1'b1;
        end else begin
            if (SYNC_STAGES > 1) begin
                sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
                csn_sync  <= {csn_sync[SYNC_STAGES-2:0],  spi_csn_i};
                mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            end else begin
                sclk_sync <= spi_sclk_i;
                csn_sync  <= spi_csn_i;
                mosi_sync <= spi_mosi_i;
            end
            sclk_d <= sclk_s;
            csn_d  <= csn_s;
        end
    end

    // Tx path: holding buffer fill, shift register reload at load points, shift on SCLK fall.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_sr         <= '0;
            hold          <= '0;
            hold_full     <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            tx_underrun_o <= 1'b0;
            if (load_pt) begin
                if (hold_full) begin
                    tx_sr     <= hold;
                    hold_full <= 1'b0;
                end else begin
                    tx_sr         <= DEFAULT_TX;
                    tx_underrun_o <= 1'b1;
                end
            end else if ((state == SHIFT) && sclk_fall) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            // Accept only happens with the buffer empty, so it never collides with a hold->tx_sr move.
            if (accept) begin
                hold      <= tx_byte_i;
                hold_full <= 1'b1;
            end
        end
    end

    // Frame FSM: selection tracking, bit counting, rx assembly and MISO drive.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            rx_sr         <= '0;
            rx_byte_o     <= '0;
            rx_valid_o    <= 1'b0;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (csn_fall) begin
                        state         <= SHIFT;
                        bit_cnt       <= '0;
                        spi_miso_oe_o <= 1'b1;
                        busy_o        <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sclk_fall) begin
                        spi_miso_o <= tx_sr[7];
                    end
                    if (sclk_rise) begin
                        rx_sr <= {rx_sr[5:0], mosi_s};
                        if (bit_cnt == 3'd7) begin
                            rx_byte_o  <= {rx_sr, mosi_s};
                            rx_valid_o <= 1'b1;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    // Deselect wins over the counter but not over a byte completing this cycle.
                    if (csn_rise) begin
                        state         <= IDLE;
                        bit_cnt       <= '0;
                        spi_miso_oe_o <= 1'b0;
                        busy_o        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Testbench for spi_slave_byte_if: drives an SPI mode-3 master at f_clk/16 and checks bytes both ways.
// Directed table of single-byte frames, hand sequences for reset/abort/deselected clocking, random frames.
// Expected values come from the frame-level rules: each load point takes the buffered byte or the default.
module tb_spi_slave_byte_if;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       spi_sclk_i, spi_csn_i, spi_mosi_i;
    logic       spi_miso_o, spi_miso_oe_o;
    logic [7:0] tx_byte_i;
    logic       tx_valid_i, tx_ready_o;
    logic [7:0] rx_byte_o;
    logic       rx_valid_o, tx_underrun_o, busy_o;

    spi_slave_byte_if #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .spi_sclk_i    (spi_sclk_i),
        .spi_csn_i     (spi_csn_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .tx_byte_i     (tx_byte_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .rx_byte_o     (rx_byte_o),
        .rx_valid_o    (rx_valid_o),
        .tx_underrun_o (tx_underrun_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Monitor: logs every rx strobe and counts pulses / enables seen.
    logic [7:0] rx_log[$];
    int         und_cnt  = 0;
    int         oe_cnt   = 0;
    int         busy_cnt = 0;
    always @(negedge clk_i) begin
        if (rx_valid_o === 1'b1) rx_log.push_back(rx_byte_o);
        if (tx_underrun_o === 1'b1) und_cnt++;
        if (spi_miso_oe_o === 1'b1) oe_cnt++;
        if (busy_o === 1'b1) busy_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(posedge clk_i);
        #1;
    endtask

    task automatic write_tx(input logic [7:0] b);
        int t = 0;
        while (tx_ready_o !== 1'b1 && t < 50) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        chk("tx_ready before write", {31'd0, tx_ready_o}, 32'd1);
        tx_byte_i  = b;
        tx_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        tx_valid_i = 1'b0;
    endtask

    // Frame description shared by the frame runner and the checks.
    logic [7:0] f_mosi[5];
    logic [7:0] f_td[5];
    logic [7:0] f_miso[5];
    bit         f_prov[5];
    int         f_rx_start, f_und_start, f_und_fall;
    logic       f_ready_before, f_ready_after;

    // Master: byte k's tx data is written ahead of load point k (CSn fall, or byte k-1's last rise).
    task automatic run_frame(input int n, input int abort_bits);
        int  bits = 0;
        bit  stop = 0;
        f_rx_start  = rx_log.size();
        f_und_start = und_cnt;
        if (f_prov[0]) write_tx(f_td[0]);
        f_ready_before = tx_ready_o;
        spi_csn_i = 1'b0;
        half();
        f_ready_after = tx_ready_o;
        f_und_fall    = und_cnt - f_und_start;
        for (int b = 0; b < n && !stop; b++) begin
            for (int i = 7; i >= 0 && !stop; i--) begin
                if (abort_bits >= 0 && bits == abort_bits) begin
                    stop = 1;
                end else begin
                    spi_sclk_i = 1'b0;
                    spi_mosi_i = f_mosi[b][i];
                    half();
                    if (i == 5 && f_prov[b+1]) write_tx(f_td[b+1]);
                    f_miso[b][i] = spi_miso_o;
                    spi_sclk_i   = 1'b1;
                    half();
                    bits++;
                end
            end
        end
        half();
        spi_csn_i = 1'b1;
        half();
        half();
    endtask

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        bit         prov;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n, exp_und, oe0, busy0;
        logic [7:0] exp_miso;

        tbl[0] = '{8'h3C, 8'hA5, 1'b1, 8'h3C, 8'hA5, 1};
        tbl[1] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 2};
        tbl[2] = '{8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00, 1};
        tbl[3] = '{8'h81, 8'h7E, 1'b1, 8'h81, 8'h7E, 1};
        tbl[4] = '{8'h55, 8'hAA, 1'b0, 8'h55, 8'hFF, 2};
        tbl[5] = '{8'h96, 8'h3C, 1'b1, 8'h96, 8'h3C, 1};

        rstn_i     = 1'b1;
        spi_sclk_i = 1'b1;
        spi_csn_i  = 1'b1;
        spi_mosi_i = 1'b0;
        tx_byte_i  = 8'h00;
        tx_valid_i = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        chk("reset outputs", {21'd0, spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_byte_o, rx_valid_o, tx_underrun_o, busy_o},
            {21'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        half();

        // Reset mid-byte with a buffered byte, then a clean byte-aligned frame.
        write_tx(8'h77);
        spi_csn_i = 1'b0;
        half();
        for (int i = 0; i < 4; i++) begin
            spi_sclk_i = 1'b0; spi_mosi_i = i[0]; half();
            spi_sclk_i = 1'b1; half();
        end
        rstn_i = 1'b0;
        #1;
        chk("mid-byte reset outputs", {21'd0, spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_byte_o, rx_valid_o, tx_underrun_o, busy_o},
            {21'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        half();
        spi_csn_i = 1'b1;
        half();
        half();
        f_mosi[0] = 8'hC6; f_td[0] = 8'h69; f_prov[0] = 1; f_prov[1] = 0;
        run_frame(1, -1);
        chk("post-reset rx count", rx_log.size() - f_rx_start, 1);
        if (rx_log.size() > f_rx_start) chk("post-reset rx byte", {24'd0, rx_log[f_rx_start]}, 32'hC6);
        chk("post-reset miso byte", {24'd0, f_miso[0]}, 32'h69);

        // Table of single-byte frames.
        foreach (tbl[k]) begin
            f_mosi[0] = tbl[k].mosi;
            f_td[0]   = tbl[k].tx;
            f_prov[0] = tbl[k].prov;
            f_prov[1] = 0;
            run_frame(1, -1);
            chk($sformatf("tbl%0d rx count", k), rx_log.size() - f_rx_start, 1);
            if (rx_log.size() > f_rx_start)
                chk($sformatf("tbl%0d rx byte", k), {24'd0, rx_log[f_rx_start]}, {24'd0, tbl[k].exp_rx});
            chk($sformatf("tbl%0d miso byte", k), {24'd0, f_miso[0]}, {24'd0, tbl[k].exp_miso});
            chk($sformatf("tbl%0d underruns", k), und_cnt - f_und_start, tbl[k].exp_und);
            chk($sformatf("tbl%0d underrun at csn fall", k), f_und_fall, tbl[k].prov ? 0 : 1);
            chk($sformatf("tbl%0d ready before fall", k), {31'd0, f_ready_before}, tbl[k].prov ? 0 : 1);
            chk($sformatf("tbl%0d ready after fall", k), {31'd0, f_ready_after}, 1);
        end

        // Two bytes in one selection, next byte buffered while the current one shifts.
        f_mosi[0] = 8'hC3; f_mosi[1] = 8'h5A;
        f_td[0] = 8'h11; f_td[1] = 8'h22; f_td[2] = 8'h33;
        f_prov[0] = 1; f_prov[1] = 1; f_prov[2] = 1;
        run_frame(2, -1);
        chk("two-byte rx count", rx_log.size() - f_rx_start, 2);
        if (rx_log.size() > f_rx_start + 1) begin
            chk("two-byte rx0", {24'd0, rx_log[f_rx_start]}, 32'hC3);
            chk("two-byte rx1", {24'd0, rx_log[f_rx_start+1]}, 32'h5A);
        end
        chk("two-byte miso0", {24'd0, f_miso[0]}, 32'h11);
        chk("two-byte miso1", {24'd0, f_miso[1]}, 32'h22);
        chk("two-byte underruns", und_cnt - f_und_start, 0);

        // Deselect after 5 bits: partial byte dropped, then a normal frame.
        f_mosi[0] = 8'hF0; f_prov[0] = 0; f_prov[1] = 0;
        run_frame(1, 5);
        chk("abort rx count", rx_log.size() - f_rx_start, 0);
        chk("abort miso_oe", {31'd0, spi_miso_oe_o}, 0);
        chk("abort busy", {31'd0, busy_o}, 0);
        f_mosi[0] = 8'h81; f_prov[0] = 0; f_prov[1] = 0;
        run_frame(1, -1);
        chk("after-abort rx count", rx_log.size() - f_rx_start, 1);
        if (rx_log.size() > f_rx_start) chk("after-abort rx byte", {24'd0, rx_log[f_rx_start]}, 32'h81);

        // SCLK toggling while deselected must be invisible.
        f_rx_start = rx_log.size();
        oe0 = oe_cnt;
        busy0 = busy_cnt;
        spi_mosi_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            spi_sclk_i = 1'b0; half();
            spi_sclk_i = 1'b1; half();
        end
        half();
        chk("deselected rx count", rx_log.size() - f_rx_start, 0);
        chk("deselected miso_oe cycles", oe_cnt - oe0, 0);
        chk("deselected busy cycles", busy_cnt - busy0, 0);

        // Random frames against the load-point model.
        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(1, 3);
            exp_und = 0;
            for (int k = 0; k <= n; k++) begin
                f_prov[k] = 1'($urandom_range(0, 1));
                f_td[k]   = 8'($urandom);
                if (!f_prov[k]) exp_und++;
            end
            for (int b = 0; b < n; b++) f_mosi[b] = 8'($urandom);
            run_frame(n, -1);
            chk($sformatf("rnd%0d rx count", r), rx_log.size() - f_rx_start, n);
            for (int b = 0; b < n; b++) begin
                exp_miso = f_prov[b] ? f_td[b] : 8'hFF;
                if (rx_log.size() > f_rx_start + b)
                    chk($sformatf("rnd%0d rx%0d", r, b), {24'd0, rx_log[f_rx_start+b]}, {24'd0, f_mosi[b]});
                chk($sformatf("rnd%0d miso%0d", r, b), {24'd0, f_miso[b]}, {24'd0, exp_miso});
            end
            chk($sformatf("rnd%0d underruns", r), und_cnt - f_und_start, exp_und);
            chk($sformatf("rnd%0d idle oe/busy", r), {30'd0, spi_miso_oe_o, busy_o}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
